// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_core hierarchy: opcodes, FSM states,
// instruction field positions and small decode helpers.
package cpu_pkg;

   // Opcode values (instruction bits [15:11])
   localparam logic [4:0] OP_NOP  = 5'd0;
   localparam logic [4:0] OP_LD   = 5'd1;
   localparam logic [4:0] OP_LN   = 5'd2;
   localparam logic [4:0] OP_CP   = 5'd3;
   localparam logic [4:0] OP_ST   = 5'd4;
   localparam logic [4:0] OP_SHL  = 5'd5;
   localparam logic [4:0] OP_ADD  = 5'd6;
   localparam logic [4:0] OP_SUB  = 5'd7;
   localparam logic [4:0] OP_JZ   = 5'd8;
   localparam logic [4:0] OP_JB   = 5'd9;
   localparam logic [4:0] OP_JMP  = 5'd10;
   localparam logic [4:0] OP_XOR  = 5'd11;
   localparam logic [4:0] OP_OR   = 5'd12;
   localparam logic [4:0] OP_AND  = 5'd13;
   localparam logic [4:0] OP_SHR  = 5'd14;
   localparam logic [4:0] OP_NOT  = 5'd15;
   localparam logic [4:0] OP_PUSH = 5'd16;
   localparam logic [4:0] OP_POP  = 5'd17;
   localparam logic [4:0] OP_HALT = 5'd31;

   // FSM state encoding, visible on o_state
   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_MEM   = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   // Instruction field positions
   localparam int OP_HI  = 15;
   localparam int OP_LO  = 11;
   localparam int RD_HI  = 10;
   localparam int RD_LO  = 8;
   localparam int RS_HI  = 7;
   localparam int RS_LO  = 5;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

   // Opcodes that go through the ALU and update Z/C
   function automatic logic is_alu_op(input logic [4:0] op);
      return op inside {OP_SHL, OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_SHR, OP_NOT};
   endfunction

   // Opcodes that need a data-memory access after EXEC
   function automatic logic is_mem_op(input logic [4:0] op);
      return op inside {OP_LD, OP_ST, OP_PUSH, OP_POP};
   endfunction

   // Everything 0..17 plus HALT is defined; the rest are illegal
   function automatic logic is_legal_op(input logic [4:0] op);
      return (op <= OP_POP) || (op == OP_HALT);
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: result y, carry/borrow c, zero z.
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [4:0]        op,
   output logic [DATA_W-1:0] y,
   output logic              c,
   output logic              z
);

   // Result and carry per opcode; logic ops leave c cleared
   always_comb begin
      y = '0;
      c = 1'b0;
      case (op)
         OP_ADD: {c, y} = {1'b0, a} + {1'b0, b};
         OP_SUB: begin
            y = a - b;
            c = (a < b);
         end
         OP_SHL: begin
            y = {a[DATA_W-2:0], 1'b0};
            c = a[DATA_W-1];
         end
         OP_SHR: begin
            y = {1'b0, a[DATA_W-1:1]};
            c = a[0];
         end
         OP_XOR: y = a ^ b;
         OP_OR:  y = a | b;
         OP_AND: y = a & b;
         OP_NOT: y = ~a;
         default: y = '0;
      endcase
      z = (y == '0);
   end

endmodule

// File: rtl/cpu_core.sv
// CPU top: FETCH/EXEC/MEM/HALT sequencer, register file, pc, sp and flags,
// with req/ack handshakes to separate instruction and data memories.
module cpu_core
   import cpu_pkg::*;
#(
   parameter int                DATA_W  = 16,
   parameter int                ADDR_W  = 16,
   parameter int                NREGS   = 4,
   parameter logic [ADDR_W-1:0] SP_INIT = 16'h0100
) (
   input  logic              clk,
   input  logic              reset,
   output logic              i_req,
   output logic [ADDR_W-1:0] i_addr,
   input  logic              i_ack,
   input  logic [15:0]       i_rdata,
   output logic              d_req,
   output logic              d_we,
   output logic [ADDR_W-1:0] d_addr,
   output logic [DATA_W-1:0] d_wdata,
   input  logic              d_ack,
   input  logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] o_pc,
   output logic [15:0]       o_ir,
   output logic [1:0]        o_state,
   output logic [1:0]        o_flags,
   output logic [ADDR_W-1:0] o_sp,
   output logic              o_halted,
   output logic              o_illegal,
   input  logic [2:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_sp;
   logic [15:0]       r_ir;
   logic              r_c;
   logic              r_z;
   logic [DATA_W-1:0] r_regs [NREGS];

   logic [4:0]        w_op;
   logic [2:0]        w_rd;
   logic [2:0]        w_rs;
   logic [7:0]        w_imm8;
   logic [DATA_W-1:0] w_rf [8];
   logic [DATA_W-1:0] w_rd_val;
   logic [DATA_W-1:0] w_rs_val;
   logic [DATA_W-1:0] w_alu_y;
   logic              w_alu_c;
   logic              w_alu_z;
   logic [DATA_W-1:0] w_ln_val;
   logic [ADDR_W-1:0] w_br_off;
   logic [ADDR_W-1:0] w_pc_inc;
   logic [ADDR_W-1:0] w_pc_br;
   logic              w_taken;
   logic              w_exec;
   logic              w_d_done;
   logic              w_stack_op;
   logic              w_rf_we;
   logic [DATA_W-1:0] w_rf_wdata;

   assign w_op   = r_ir[OP_HI:OP_LO];
   assign w_rd   = r_ir[RD_HI:RD_LO];
   assign w_rs   = r_ir[RS_HI:RS_LO];
   assign w_imm8 = r_ir[IMM_HI:IMM_LO];

   // Eight-entry read view of the register file; indices past NREGS read as 0
   for (genvar gi = 0; gi < 8; gi++) begin : g_rf
      if (gi < NREGS) begin : g_real
         assign w_rf[gi] = r_regs[gi];
      end else begin : g_zero
         assign w_rf[gi] = '0;
      end
   end

   assign w_rd_val = w_rf[w_rd];
   assign w_rs_val = w_rf[w_rs];
   assign dbg_data = w_rf[dbg_sel];

   cpu_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .a  (w_rd_val),
      .b  (w_rs_val),
      .op (w_op),
      .y  (w_alu_y),
      .c  (w_alu_c),
      .z  (w_alu_z)
   );

   // Sign-extended immediates for LN and relative branches
   assign w_ln_val = DATA_W'($signed(w_imm8));
   assign w_br_off = ADDR_W'($signed(w_imm8));
   assign w_pc_inc = r_pc + ADDR_W'(1);
   assign w_pc_br  = w_pc_inc + w_br_off;
   assign w_taken  = (w_op == OP_JMP) || ((w_op == OP_JZ) && r_z) || ((w_op == OP_JB) && r_c);

   assign w_exec     = (r_state == ST_EXEC);
   assign w_d_done   = (r_state == ST_MEM) && d_ack;
   assign w_stack_op = (w_op == OP_PUSH) || (w_op == OP_POP);

   // Memory ports; requests are gated by reset so they drop the moment it asserts
   assign i_req   = reset && (r_state == ST_FETCH);
   assign i_addr  = r_pc;
   assign d_req   = reset && (r_state == ST_MEM);
   assign d_we    = (w_op == OP_ST) || (w_op == OP_PUSH);
   assign d_addr  = w_stack_op ? r_sp : w_rs_val[ADDR_W-1:0];
   assign d_wdata = w_rd_val;

   // Register write port: ALU/LN/CP in EXEC, LD/POP on data completion
   assign w_rf_we = (w_exec && (is_alu_op(w_op) || (w_op == OP_LN) || (w_op == OP_CP))) ||
                    (w_d_done && ((w_op == OP_LD) || (w_op == OP_POP)));

   // Select the value written back to rd
   always_comb begin
      w_rf_wdata = w_alu_y;
      case (w_op)
         OP_LD, OP_POP: w_rf_wdata = d_rdata;
         OP_LN:         w_rf_wdata = w_ln_val;
         OP_CP:         w_rf_wdata = w_rs_val;
         default:       w_rf_wdata = w_alu_y;
      endcase
   end

   // Register file storage; writes to rd >= NREGS match no entry and are dropped
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < NREGS; k++) begin
            r_regs[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NREGS; k++) begin
            if (w_rf_we && (w_rd == 3'(k))) begin
               r_regs[k] <= w_rf_wdata;
            end
         end
      end
   end

   // Instruction sequencer with pc, sp, ir and flag updates
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_FETCH;
         r_pc    <= '0;
         r_sp    <= SP_INIT;
         r_ir    <= '0;
         r_c     <= 1'b0;
         r_z     <= 1'b0;
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (i_ack) begin
                  r_ir    <= i_rdata;
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_pc <= w_taken ? w_pc_br : w_pc_inc;
               if (is_alu_op(w_op)) begin
                  r_c <= w_alu_c;
                  r_z <= w_alu_z;
               end
               // PUSH pre-decrements so the MEM cycle writes at the new sp
               if (w_op == OP_PUSH) begin
                  r_sp <= r_sp - ADDR_W'(1);
               end
               if (w_op == OP_HALT) begin
                  r_state <= ST_HALT;
               end else if (is_mem_op(w_op)) begin
                  r_state <= ST_MEM;
               end else begin
                  r_state <= ST_FETCH;
               end
            end
            ST_MEM: begin
               if (d_ack) begin
                  if (w_op == OP_POP) begin
                     r_sp <= r_sp + ADDR_W'(1);
                  end
                  r_state <= ST_FETCH;
               end
            end
            default: r_state <= ST_HALT;
         endcase
      end
   end

   assign o_pc      = r_pc;
   assign o_ir      = r_ir;
   assign o_state   = r_state;
   assign o_flags   = {r_c, r_z};
   assign o_sp      = r_sp;
   assign o_halted  = (r_state == ST_HALT);
   assign o_illegal = w_exec && !is_legal_op(w_op);

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: a small program covering arithmetic, branches,
// stack, wait states, illegal opcode, HALT and a reset during a data access.
module tb_cpu_core;

   localparam int LIMIT = 100;

   logic        clk;
   logic        rst_n;
   logic        i_req;
   logic [15:0] i_addr;
   logic        i_ack;
   logic [15:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_ack;
   logic [15:0] d_rdata;
   logic [15:0] o_pc;
   logic [15:0] o_ir;
   logic [1:0]  o_state;
   logic [1:0]  o_flags;
   logic [15:0] o_sp;
   logic        o_halted;
   logic        o_illegal;
   logic [2:0]  dbg_sel;
   logic [15:0] dbg_data;

   logic [15:0] rom  [64];
   logic [15:0] dmem [512];
   int          i_wait;
   int          d_wait;
   int          i_cnt;
   int          d_cnt;

   int          n_total;
   int          n_bad;
   int          g_ill;
   int          g_unstable;
   logic [15:0] g_daddr;
   logic [15:0] g_dwdata;
   logic        g_dwe;
   logic [15:0] g_sp_mem;

   cpu_core dut (
      .clk       (clk),
      .reset     (rst_n),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_ack     (i_ack),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack),
      .d_rdata   (d_rdata),
      .o_pc      (o_pc),
      .o_ir      (o_ir),
      .o_state   (o_state),
      .o_flags   (o_flags),
      .o_sp      (o_sp),
      .o_halted  (o_halted),
      .o_illegal (o_illegal),
      .dbg_sel   (dbg_sel),
      .dbg_data  (dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory responders: ack after a programmable number of wait cycles
   assign i_ack   = i_req && (i_cnt >= i_wait);
   assign i_rdata = rom[i_addr[5:0]];
   assign d_ack   = d_req && (d_cnt >= d_wait);
   assign d_rdata = dmem[d_addr[8:0]];

   always @(posedge clk) begin
      if (i_req && !i_ack) i_cnt <= i_cnt + 1;
      else                 i_cnt <= 0;
      if (d_req && !d_ack) d_cnt <= d_cnt + 1;
      else                 d_cnt <= 0;
      if (d_req && d_ack && d_we) dmem[d_addr[8:0]] <= d_wdata;
   end

   function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] rd, input logic [7:0] lo);
      return {op, rd, lo};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_reg(input int r, input logic [15:0] exp);
      dbg_sel = 3'(r);
      #1;
      chk($sformatf("R%0d", r), dbg_data, exp);
   endtask

   // Run one instruction from its FETCH cycle to the next FETCH (or HALT)
   task automatic run_instr(output int cyc);
      logic [15:0] a0;
      logic [15:0] ir0;
      logic [15:0] pc0;
      logic        first;
      int          n;
      n = 0;
      a0 = i_addr;
      ir0 = o_ir;
      pc0 = o_pc;
      first = 1'b1;
      g_ill = 0;
      g_unstable = 0;
      while (o_state == 2'd0 && n < LIMIT) begin
         if (i_addr !== a0 || o_ir !== ir0 || i_req !== 1'b1) g_unstable++;
         @(negedge clk);
         n++;
      end
      while (o_state != 2'd0 && o_state != 2'd3 && n < LIMIT) begin
         if (o_illegal) g_ill++;
         if (o_state == 2'd2) begin
            if (first) begin
               g_daddr = d_addr;
               g_dwdata = d_wdata;
               g_dwe = d_we;
               g_sp_mem = o_sp;
               first = 1'b0;
            end else if (d_addr !== g_daddr || d_wdata !== g_dwdata || d_we !== g_dwe) begin
               g_unstable++;
            end
         end
         @(negedge clk);
         n++;
      end
      if (n >= LIMIT) begin
         n_total++;
         n_bad++;
         $display("FAIL timeout: pc=%h state=%0d after %0d cycles, required completion", pc0, o_state, n);
      end
      cyc = n;
      $display("instr pc=%h ir=%h cycles=%0d pc_next=%h flags=%b sp=%h", pc0, o_ir, n, o_pc, o_flags, o_sp);
   endtask

   initial begin
      int cyc;
      int hi;
      int n;
      n_total = 0;
      n_bad = 0;
      i_wait = 0;
      d_wait = 0;
      dbg_sel = 3'd0;
      rst_n = 1'b0;
      for (int k = 0; k < 64; k++) rom[k] = 16'h0000;
      rom[0]  = enc(5'd2,  3'd0, 8'h05);          // LN  R0,#5
      rom[1]  = enc(5'd2,  3'd1, 8'hFD);          // LN  R1,#-3
      rom[2]  = enc(5'd6,  3'd0, {3'd1, 5'd0});   // ADD R0,R1
      rom[3]  = enc(5'd7,  3'd0, {3'd0, 5'd0});   // SUB R0,R0
      rom[4]  = enc(5'd8,  3'd0, 8'h02);          // JZ  +2 -> 7
      rom[5]  = enc(5'd31, 3'd0, 8'h00);          // HALT (skipped)
      rom[6]  = enc(5'd31, 3'd0, 8'h00);          // HALT (skipped)
      rom[7]  = enc(5'd9,  3'd0, 8'h03);          // JB  +3, C=0
      rom[8]  = enc(5'd2,  3'd0, 8'h42);          // LN  R0,#0x42
      rom[9]  = enc(5'd16, 3'd0, 8'h00);          // PUSH R0
      rom[10] = enc(5'd17, 3'd1, 8'h00);          // POP R1
      rom[11] = enc(5'd2,  3'd2, 8'h20);          // LN  R2,#0x20
      rom[12] = enc(5'd4,  3'd1, {3'd2, 5'd0});   // ST  R1,[R2]
      rom[13] = enc(5'd1,  3'd3, {3'd2, 5'd0});   // LD  R3,[R2]
      rom[14] = enc(5'd20, 3'd0, 8'h00);          // illegal
      rom[15] = enc(5'd15, 3'd2, 8'h00);          // NOT R2
      rom[16] = enc(5'd31, 3'd0, 8'h00);          // HALT

      // Reset values while reset is held
      repeat (3) @(negedge clk);
      chk("rst_ireq", i_req, 1'b0);
      chk("rst_dreq", d_req, 1'b0);
      chk("rst_pc", o_pc, 16'h0000);
      chk("rst_sp", o_sp, 16'h0100);
      chk("rst_state", o_state, 2'd0);
      chk("rst_flags", o_flags, 2'b00);
      chk_reg(0, 16'h0000);

      rst_n = 1'b1;
      #1;
      chk("rel_ireq", i_req, 1'b1);
      chk("rel_iaddr", i_addr, 16'h0000);

      run_instr(cyc);                                   // LN R0,#5
      chk("ln_cycles", cyc, 2);
      run_instr(cyc);                                   // LN R1,#-3
      run_instr(cyc);                                   // ADD
      chk("add_flags", o_flags, 2'b10);
      chk_reg(0, 16'h0002);
      chk_reg(1, 16'hFFFD);
      run_instr(cyc);                                   // SUB R0,R0
      chk("sub_flags", o_flags, 2'b01);
      chk_reg(0, 16'h0000);
      run_instr(cyc);                                   // JZ taken
      chk("jz_pc", o_pc, 16'h0007);
      chk("jz_iaddr", i_addr, 16'h0007);
      chk("jz_cycles", cyc, 2);
      run_instr(cyc);                                   // JB not taken
      chk("jb_pc", o_pc, 16'h0008);
      chk("jb_flags", o_flags, 2'b01);
      run_instr(cyc);                                   // LN R0,#0x42
      run_instr(cyc);                                   // PUSH R0
      chk("push_cycles", cyc, 3);
      chk("push_addr", g_daddr, 16'h00FF);
      chk("push_we", g_dwe, 1'b1);
      chk("push_wdata", g_dwdata, 16'h0042);
      chk("push_sp", o_sp, 16'h00FF);
      run_instr(cyc);                                   // POP R1
      chk("pop_addr", g_daddr, 16'h00FF);
      chk("pop_we", g_dwe, 1'b0);
      chk("pop_sp", o_sp, 16'h0100);
      chk_reg(1, 16'h0042);
      run_instr(cyc);                                   // LN R2,#0x20
      d_wait = 2;
      run_instr(cyc);                                   // ST R1,[R2], 2 waits
      d_wait = 0;
      chk("st_cycles", cyc, 5);
      chk("st_stable", g_unstable, 0);
      chk("st_addr", g_daddr, 16'h0020);
      chk("st_wdata", g_dwdata, 16'h0042);
      chk("st_we", g_dwe, 1'b1);
      run_instr(cyc);                                   // LD R3,[R2]
      chk_reg(3, 16'h0042);
      chk("ld_flags", o_flags, 2'b01);
      i_wait = 3;
      run_instr(cyc);                                   // illegal, 3 fetch waits
      i_wait = 0;
      chk("ifw_cycles", cyc, 5);
      chk("ifw_stable", g_unstable, 0);
      chk("ill_ir", o_ir, 16'hA000);
      chk("ill_pulse", g_ill, 1);
      chk("ill_pc", o_pc, 16'h000F);
      run_instr(cyc);                                   // NOT R2
      chk("not_flags", o_flags, 2'b00);
      chk_reg(2, 16'hFFDF);
      chk_reg(4, 16'h0000);
      run_instr(cyc);                                   // HALT
      chk("halt_halted", o_halted, 1'b1);
      chk("halt_state", o_state, 2'd3);
      hi = 0;
      repeat (100) begin
         @(negedge clk);
         if (i_req) hi++;
      end
      chk("halt_ireq", hi, 0);
      chk("halt_state2", o_state, 2'd3);
      chk("halt_pc", o_pc, 16'h0011);

      // Restart, run up to PUSH and reset in the middle of its MEM phase
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 7; k++) run_instr(cyc);
      d_wait = 50;
      n = 0;
      while (o_state != 2'd2 && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("mid_dreq_hi", d_req, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_dreq_lo", d_req, 1'b0);
      chk("mid_pc", o_pc, 16'h0000);
      chk("mid_sp", o_sp, 16'h0100);
      chk("mid_state", o_state, 2'd0);
      chk_reg(0, 16'h0000);
      d_wait = 0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_rel_ireq", i_req, 1'b1);
      chk("mid_rel_iaddr", i_addr, 16'h0000);
      run_instr(cyc);
      chk_reg(0, 16'h0005);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/cpu_core.md
# cpu_core

Parametrised successor to the 16-bit beat-sequenced CPU top. It replaces the fixed beat counter and fixed-latency code ROM with a FETCH/EXEC/MEM state machine, a NREGS-entry register file, a dedicated stack pointer, Z/C flags, and req/ack handshakes to separate instruction and data memories. It keeps the 18-instruction set and adds HALT, an illegal-opcode indication, and a debug read port. It sits at the top of the CPU hierarchy, between the code/data memory wrappers and the board-level observers.

## Interface
- DATA_W, 16, register/ALU/data-bus width; must be >= 8.
- ADDR_W, 16, code and data address width; must be <= DATA_W.
- NREGS, 4, number of general registers; range 2..8.
- SP_INIT, 16'h0100, stack pointer reset value (ADDR_W bits).
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  out  1  instruction fetch request.
- i_addr  out  ADDR_W  fetch address (= pc).
- i_ack  in  1  fetch complete; i_rdata valid in this cycle.
- i_rdata  in  16  instruction word.
- d_req  out  1  data access request.
- d_we  out  1  1 = write, 0 = read; valid while d_req=1.
- d_addr  out  ADDR_W  data address.
- d_wdata  out  DATA_W  write data.
- d_ack  in  1  data access complete; d_rdata valid in this cycle on reads.
- d_rdata  in  DATA_W  read data.
- o_pc  out  ADDR_W  program counter.
- o_ir  out  16  instruction register.
- o_state  out  2  FSM state: 0 FETCH, 1 EXEC, 2 MEM, 3 HALT.
- o_flags  out  2  {C,Z}.
- o_sp  out  ADDR_W  stack pointer.
- o_halted  out  1  high while in HALT.
- o_illegal  out  1  one-cycle pulse on an illegal opcode.
- dbg_sel  in  3  debug register select.
- dbg_data  out  DATA_W  R[dbg_sel], combinational; 0 if dbg_sel >= NREGS.

## Operation
- Instruction format: op = [15:11], rd = [10:8], rs = [7:5], imm8 = [7:0].
- Register indices >= NREGS read as 0; writes to them are dropped.
- Opcodes:
  - 0 NOP.
  - 1 LD: rd <- mem[R[rs]].
  - 2 LN: rd <- sext(imm8).
  - 3 CP: rd <- R[rs].
  - 4 ST: mem[R[rs]] <- R[rd].
  - 5 SHL: rd <- rd << 1.
  - 6 ADD: rd <- rd + rs.
  - 7 SUB: rd <- rd - rs.
  - 8 JZ.
  - 9 JB.
  - 10 JMP.
  - 11 XOR, 12 OR, 13 AND: rd <- rd op rs.
  - 14 SHR: rd <- rd >> 1, logical.
  - 15 NOT: rd <- ~rd.
  - 16 PUSH.
  - 17 POP.
  - 31 HALT.
  - All other opcodes are illegal: executed as NOP and o_illegal pulses.
- Branches (JZ taken if Z; JB taken if C; JMP always): pc <- pc + 1 + sext(imm8), modulo 2^ADDR_W. Not taken: pc <- pc + 1.
- Flags:
  - ADD: C = carry-out.
  - SUB: C = borrow (rd < rs unsigned).
  - SHL: C = bit shifted out at MSB.
  - SHR: C = bit shifted out at LSB.
  - Logic ops and NOT clear C.
  - Z = (result == 0) for all ALU ops.
  - All other instructions leave flags unchanged.
- PUSH: in EXEC, sp <- sp - 1; in MEM, write R[rd] to the new sp.
- POP: in MEM, read at sp; on d_ack, rd <- d_rdata and sp <- sp + 1.
- sp wraps modulo 2^ADDR_W with no fault.
- Data addresses from registers: R[rs][ADDR_W-1:0].
- FSM:
  - FETCH: i_req = 1. On i_ack, ir <- i_rdata, go to EXEC.
  - EXEC: ALU/CP/LN writeback and flag update; pc update for every instruction. LD/ST/PUSH/POP go to MEM; HALT goes to HALT; all others go to FETCH.
  - MEM: d_req = 1. On d_ack, complete the access and go to FETCH.
  - HALT: terminal; only reset leaves it.
- Reset state: pc = 0, ir = 0, all registers 0, sp = SP_INIT, flags 0, state FETCH. While reset is low, i_req and d_req are forced to 0; all other outputs reflect the reset values.

## Timing
- Handshake: req is held high, with address/we/wdata stable, until the rising edge where req & ack are both 1. A same-cycle (combinational) ack is legal. ack while req = 0 is ignored.
- Zero-wait throughput: 2 cycles for ALU, branch, NOP and LN; 3 cycles for LD, ST, PUSH and POP. Each wait cycle on ack adds one cycle.
- First i_req is in the first cycle after reset deasserts, with i_addr = 0.
- Register, flag and pc updates take effect at the EXEC edge (MEM-completion edge for LD/POP) and are visible on the outputs in the next cycle.
- o_illegal is high for exactly the EXEC cycle of the illegal instruction.
- Reset asserted mid-transaction: req drops asynchronously and the transaction is abandoned. Memories must tolerate a dropped req.

## Structure
- Package cpu_pkg holds:
  - opcode localparams;
  - state encoding;
  - instruction field slice constants.
- Sub-module cpu_alu, combinational, parametrised by DATA_W: inputs a, b, op; outputs y, c, z.
- Register file, sp, pc and FSM live in cpu_core.

## Test plan
- Reset: assert reset mid-MEM → d_req=0 immediately; pc=0, sp=0x0100, registers 0. Release → i_req=1 with i_addr=0.
- Arithmetic: LN R0,#5; LN R1,#0xFD; ADD R0,R1 → R0=0x0002, C=1, Z=0.
- Branch: SUB R0,R0 → Z=1; JZ +2 at pc=4 → next i_addr=7. JB with C=0 → pc+1.
- Stack: sp=0x0100; PUSH R0 → write at 0x00FF, sp=0x00FF. POP R1 → read at 0x00FF, R1=d_rdata, sp=0x0100.
- Wait states: i_ack delayed 3 cycles → i_req and i_addr stable, ir unchanged until ack. d_ack delayed 2 cycles on ST → d_wdata and d_addr stable.
- Halt/illegal: opcode 20 → o_illegal pulses 1 cycle, pc+1. HALT → o_halted=1, o_state=3, i_req=0 for 100 cycles, until reset.
